// File: rtl/counter_timer_ctrl.sv
`default_nettype none
//============================================================================
// Module      : counter_timer_ctrl
// Description : Timer controller for an external up/down counter. Divides the
//               clock into count ticks, loads the reload value into the
//               counter, and watches the counter's terminal flag to detect
//               expiry. On expiry it either reloads (periodic) or stops
//               (one-shot). Provides a sticky interrupt with an overflow flag.
// Ports       :
//   clk_i             clock, rising edge
//   rstn_i            synchronous reset, active low
//   start_i           pulse: latch configuration and (re)start the timer
//   stop_i            pulse: abort to IDLE (wins over start_i)
//   mode_periodic_i   1 = periodic, 0 = one-shot (latched on start)
//   dir_up_i          1 = count up, 0 = count down (latched on start)
//   reload_i          counter load value (latched on start)
//   presc_i           prescale divisor minus one (latched on start)
//   irq_clr_i         clears irq_o and irq_ovf_o
//   cnt_is_max_min_i  counter terminal flag (max when up, zero when down)
//   cnt_en_o          counter count enable
//   cnt_up_down_o     counter direction (latched dir)
//   cnt_load_en_o     counter load enable
//   cnt_load_count_o  counter load value (latched reload)
//   busy_o            timer is loading or running
//   done_o            one-shot run has finished
//   expiry_o          single-cycle pulse on each expiry
//   irq_o             sticky expiry interrupt
//   irq_ovf_o         sticky: expiry occurred while irq_o was still set
// Revision    : 1.0 - initial release
//============================================================================
module counter_timer_ctrl #(
    parameter int WIDTH       = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   mode_periodic_i,
    input  logic                   dir_up_i,
    input  logic [WIDTH-1:0]       reload_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    input  logic                   irq_clr_i,
    input  logic                   cnt_is_max_min_i,
    output logic                   cnt_en_o,
    output logic                   cnt_up_down_o,
    output logic                   cnt_load_en_o,
    output logic [WIDTH-1:0]       cnt_load_count_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   expiry_o,
    output logic                   irq_o,
    output logic                   irq_ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [WIDTH-1:0]       reload_q;
    logic                   dir_q;
    logic                   mode_q;
    logic                   irq;
    logic                   irq_ovf;

    logic tick;
    logic expiry;

    // A tick is the last cycle of each prescale period while running. A tick
    // that finds the counter already at its terminal value is an expiry: the
    // counter is not advanced, it is reloaded (periodic) or left holding.
    always_comb begin
        tick          = (state == RUN) && (presc_cnt == presc_q);
        expiry        = tick && cnt_is_max_min_i;
        cnt_en_o      = tick && !cnt_is_max_min_i;
        cnt_load_en_o = (state == LOAD) || (expiry && mode_q);
    end

    assign cnt_up_down_o    = dir_q;
    assign cnt_load_count_o = reload_q;
    assign busy_o           = (state == LOAD) || (state == RUN);
    assign done_o           = (state == DONE);
    assign expiry_o         = expiry;
    assign irq_o            = irq;
    assign irq_ovf_o        = irq_ovf;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            presc_cnt <= '0;
            presc_q   <= '0;
            reload_q  <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            irq       <= 1'b0;
            irq_ovf   <= 1'b0;
        end else begin
            // Overflow looks at the pre-update irq; a same-cycle clear
            // suppresses it since software has just acknowledged.
            if (expiry && irq && !irq_clr_i) begin
                irq_ovf <= 1'b1;
            end else if (irq_clr_i) begin
                irq_ovf <= 1'b0;
            end

            if (expiry) begin
                irq <= 1'b1;
            end else if (irq_clr_i) begin
                irq <= 1'b0;
            end

            // Prescaler only advances while running; it wraps on each tick,
            // so a periodic reload continues on the same cadence.
            if (state == RUN) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_WIDTH'(1);
            end else begin
                presc_cnt <= '0;
            end

            if (stop_i) begin
                state <= IDLE;
            end else if (start_i) begin
                state    <= LOAD;
                mode_q   <= mode_periodic_i;
                dir_q    <= dir_up_i;
                reload_q <= reload_i;
                presc_q  <= presc_i;
            end else begin
                case (state)
                    LOAD:    state <= RUN;
                    RUN:     if (expiry && !mode_q) state <= DONE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
